// File: rtl/coin_detector_if.sv
// Consumer-facing handshake between the coin detector and the coin casher.
// The detector drives coin/return valids; the casher drives en (its wait_ready).
interface coin_detector_if;
    logic       en;
    logic       coin_insert;
    logic [2:0] coin_type;
    logic       return_coin;

    modport master (
        input  en,
        output coin_insert,
        output coin_type,
        output return_coin
    );

    modport slave (
        output en,
        input  coin_insert,
        input  coin_type,
        input  return_coin
    );
endinterface

// File: rtl/coin_detector.sv
// Optical coin-slot width classifier with jam detection and a debounced return button.
// Coin and return requests are level-valid toward the casher; return has priority.
module coin_detector #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned NOISE_MAX   = 3,
    parameter int unsigned W10         = 20,
    parameter int unsigned W25         = 40,
    parameter int unsigned W100        = 60,
    parameter int unsigned W200        = 80,
    parameter int unsigned W_MAX       = 100,
    parameter int unsigned JAM_CYCLES  = 1000,
    parameter int unsigned DEB_CYCLES  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             coin_sense,
    input  logic             return_btn,
    coin_detector_if.master  bus,
    output logic             slot_block,
    output logic             sense_err
);

    localparam logic [15:0] NoiseMaxC = 16'(NOISE_MAX);
    localparam logic [15:0] W10C      = 16'(W10);
    localparam logic [15:0] W25C      = 16'(W25);
    localparam logic [15:0] W100C     = 16'(W100);
    localparam logic [15:0] W200C     = 16'(W200);
    localparam logic [15:0] WMaxC     = 16'(W_MAX);
    localparam logic [15:0] JamC      = 16'(JAM_CYCLES);
    localparam logic [15:0] DebC      = 16'(DEB_CYCLES);

    typedef enum logic [1:0] {StIdle, StMeasure, StPend, StJam} state_e;

    logic [SYNC_STAGES-1:0] sense_sync_q, sense_sync_d;
    logic [SYNC_STAGES-1:0] btn_sync_q, btn_sync_d;
    state_e                 state_q, state_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [2:0]             coin_type_q, coin_type_d;
    logic                   coin_insert_q, coin_insert_d;
    logic                   slot_block_q, slot_block_d;
    logic                   sense_err_q, sense_err_d;
    logic                   deb_level_q, deb_level_d;
    logic [15:0]            deb_cnt_q, deb_cnt_d;
    logic                   ret_pend_q, ret_pend_d;
    logic                   sense, btn, deb_rise;

    function automatic logic [2:0] classify(input logic [15:0] w);
        if (w < W10C)       return 3'b001;
        else if (w < W25C)  return 3'b010;
        else if (w < W100C) return 3'b011;
        else if (w < W200C) return 3'b100;
        else if (w < WMaxC) return 3'b101;
        else                return 3'b000;
    endfunction

    always_comb begin
        sense_sync_d = {sense_sync_q[SYNC_STAGES-2:0], coin_sense};
        btn_sync_d   = {btn_sync_q[SYNC_STAGES-2:0], return_btn};
        sense        = sense_sync_q[SYNC_STAGES-1];
        btn          = btn_sync_q[SYNC_STAGES-1];

        state_d     = state_q;
        cnt_d       = cnt_q;
        coin_type_d = coin_type_q;

        unique case (state_q)
            StIdle: begin
                if (sense) begin
                    state_d = StMeasure;
                    cnt_d   = 16'd1;
                end
            end
            StMeasure: begin
                if (sense) begin
                    if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                    if (cnt_d >= JamC) state_d = StJam;
                end else if (cnt_q <= NoiseMaxC) begin
                    state_d = StIdle;
                end else begin
                    state_d     = StPend;
                    coin_type_d = classify(cnt_q);
                end
            end
            StPend: begin
                // A pending return request blocks coin consumption on this edge.
                if (bus.en && !ret_pend_q) state_d = StIdle;
            end
            StJam: begin
                if (!sense) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (state_d != StPend) coin_type_d = 3'b000;
        if (state_d == StIdle) cnt_d = 16'd0;

        coin_insert_d = (state_d == StPend);
        slot_block_d  = (state_d != StIdle);
        sense_err_d   = (state_d == StJam);

        // Debounce: a new level is taken only after DEB_CYCLES consecutive differing samples.
        deb_level_d = deb_level_q;
        deb_cnt_d   = 16'd0;
        deb_rise    = 1'b0;
        if (btn != deb_level_q) begin
            if (deb_cnt_q == DebC - 16'd1) begin
                deb_level_d = btn;
                deb_rise    = btn;
            end else begin
                deb_cnt_d = deb_cnt_q + 16'd1;
            end
        end

        ret_pend_d = ret_pend_q;
        if (deb_rise)    ret_pend_d = 1'b1;
        else if (bus.en) ret_pend_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sense_sync_q  <= '0;
            btn_sync_q    <= '0;
            state_q       <= StIdle;
            cnt_q         <= 16'd0;
            coin_type_q   <= 3'b000;
            coin_insert_q <= 1'b0;
            slot_block_q  <= 1'b0;
            sense_err_q   <= 1'b0;
            deb_level_q   <= 1'b0;
            deb_cnt_q     <= 16'd0;
            ret_pend_q    <= 1'b0;
        end else begin
            sense_sync_q  <= sense_sync_d;
            btn_sync_q    <= btn_sync_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            coin_type_q   <= coin_type_d;
            coin_insert_q <= coin_insert_d;
            slot_block_q  <= slot_block_d;
            sense_err_q   <= sense_err_d;
            deb_level_q   <= deb_level_d;
            deb_cnt_q     <= deb_cnt_d;
            ret_pend_q    <= ret_pend_d;
        end
    end

    assign bus.coin_insert = coin_insert_q;
    assign bus.coin_type   = coin_type_q;
    assign bus.return_coin = ret_pend_q;
    assign slot_block      = slot_block_q;
    assign sense_err       = sense_err_q;

endmodule

// File: tb/tb_coin_detector.sv
// Bench for coin_detector: width table plus hand sequences for hold, jam, return and reset.
// Expected coin types go into a queue at stimulus time and are popped on each consume.
module tb_coin_detector;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic coin_sense = 1'b0;
    logic return_btn = 1'b0;
    logic slot_block, sense_err;

    always #5 clk = ~clk;

    coin_detector_if bus();

    coin_detector #(
        .SYNC_STAGES(2), .NOISE_MAX(3), .W10(20), .W25(40), .W100(60), .W200(80),
        .W_MAX(100), .JAM_CYCLES(1000), .DEB_CYCLES(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .coin_sense (coin_sense),
        .return_btn (return_btn),
        .bus        (bus),
        .slot_block (slot_block),
        .sense_err  (sense_err)
    );

    typedef struct {
        int unsigned width;
        logic        report;
        logic [2:0]  ctype;
    } vec_t;

    int         n_vec = 0;
    int         n_err = 0;
    int         ins_cnt = 0;
    int         ret_cnt = 0;
    logic [2:0] exp_q[$];
    logic [2:0] mon_exp;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    // Consumer-side monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.coin_insert) ins_cnt++;
            if (bus.return_coin && bus.en) ret_cnt++;
            if (bus.coin_insert && bus.en && !bus.return_coin) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_coin: got type %0d, required no report",
                             bus.coin_type);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("coin_type", 32'(bus.coin_type), 32'(mon_exp));
                end
            end
        end
    end

    task automatic drive_coin(input int unsigned w);
        @(posedge clk);
        #2 coin_sense = 1'b1;
        repeat (w) @(posedge clk);
        #2 coin_sense = 1'b0;
    endtask

    task automatic wait_insert(input int limit, output int found);
        found = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.coin_insert) begin
                found = 1;
                break;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        int   found, cyc, held, r0, i0;

        vecs[0] = '{3,   1'b0, 3'b000};
        vecs[1] = '{4,   1'b1, 3'b001};
        vecs[2] = '{19,  1'b1, 3'b001};
        vecs[3] = '{20,  1'b1, 3'b010};
        vecs[4] = '{39,  1'b1, 3'b010};
        vecs[5] = '{40,  1'b1, 3'b011};
        vecs[6] = '{60,  1'b1, 3'b100};
        vecs[7] = '{99,  1'b1, 3'b101};
        vecs[8] = '{100, 1'b1, 3'b000};

        bus.en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_coin_insert", 32'(bus.coin_insert), 0);
        check("rst_coin_type",   32'(bus.coin_type), 0);
        check("rst_return_coin", 32'(bus.return_coin), 0);
        check("rst_slot_block",  32'(slot_block), 0);
        check("rst_sense_err",   32'(sense_err), 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        bus.en = 1'b1;

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].report) exp_q.push_back(vecs[i].ctype);
            drive_coin(vecs[i].width);
            repeat (12) @(negedge clk);
            check($sformatf("w%0d_drain", vecs[i].width), 32'(exp_q.size()), 0);
            check($sformatf("w%0d_idle_insert", vecs[i].width), 32'(bus.coin_insert), 0);
            check($sformatf("w%0d_idle_type", vecs[i].width), 32'(bus.coin_type), 0);
            check($sformatf("w%0d_idle_block", vecs[i].width), 32'(slot_block), 0);
        end

        // 65-cycle coin with en high: one-cycle valid, 3-edge latency after the fall.
        i0 = ins_cnt;
        exp_q.push_back(3'b100);
        @(posedge clk);
        #2 coin_sense = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("w65_block_measure", 32'(slot_block), 1);
        repeat (55) @(posedge clk);
        #2 coin_sense = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("w65_latency_e2", 32'(bus.coin_insert), 0);
        check("w65_block_pend", 32'(slot_block), 1);
        @(negedge clk);
        check("w65_latency_e3", 32'(bus.coin_insert), 1);
        @(negedge clk);
        check("w65_consumed", 32'(bus.coin_insert), 0);
        check("w65_block_after", 32'(slot_block), 0);
        check("w65_insert_cycles", 32'(ins_cnt - i0), 1);

        // en low: the 10c coin must stay valid until en rises.
        bus.en = 1'b0;
        exp_q.push_back(3'b010);
        drive_coin(25);
        wait_insert(10, found);
        check("hold_found", 32'(found), 1);
        held = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.coin_insert && bus.coin_type == 3'b010) held++;
        end
        check("hold_cycles", 32'(held), 50);
        @(posedge clk);
        #2 bus.en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("hold_consumed", 32'(bus.coin_insert), 0);
        check("hold_drain", 32'(exp_q.size()), 0);

        // Return press while a coin is pending: return consumed first, coin next.
        bus.en = 1'b0;
        exp_q.push_back(3'b010);
        drive_coin(25);
        wait_insert(10, found);
        check("ret_coin_found", 32'(found), 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #2 return_btn = (i % 2 == 0);
        end
        repeat (30) @(posedge clk);
        #2 return_btn = 1'b0;
        @(negedge clk);
        check("ret_pending", 32'(bus.return_coin), 1);
        check("ret_coin_still", 32'(bus.coin_insert), 1);
        r0 = ret_cnt;
        @(posedge clk);
        #2 bus.en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ret_cleared", 32'(bus.return_coin), 0);
        check("ret_coin_kept", 32'(bus.coin_insert), 1);
        @(negedge clk);
        check("ret_coin_consumed", 32'(bus.coin_insert), 0);
        check("ret_once", 32'(ret_cnt - r0), 1);
        repeat (30) @(negedge clk);
        check("ret_no_repeat", 32'(ret_cnt - r0), 1);
        check("ret_drain", 32'(exp_q.size()), 0);

        // Jam: raw high on the first edge, two sync flops, then 1000 counted edges.
        i0 = ins_cnt;
        @(posedge clk);
        #2 coin_sense = 1'b1;
        cyc = 0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            cyc++;
            if (sense_err) break;
        end
        check("jam_latency", 32'(cyc), 1003);
        check("jam_block", 32'(slot_block), 1);
        r0 = ret_cnt;
        @(posedge clk);
        #2 return_btn = 1'b1;
        repeat (30) @(posedge clk);
        #2 return_btn = 1'b0;
        repeat (30) @(posedge clk);
        check("jam_return", 32'(ret_cnt - r0), 1);
        check("jam_still", 32'(sense_err), 1);
        #2 coin_sense = 1'b0;
        repeat (5) @(negedge clk);
        check("jam_exit_err", 32'(sense_err), 0);
        check("jam_exit_block", 32'(slot_block), 0);
        check("jam_no_coin", 32'(ins_cnt - i0), 0);

        // Asynchronous reset while a coin is pending discards it.
        bus.en = 1'b0;
        exp_q.push_back(3'b010);
        drive_coin(25);
        wait_insert(10, found);
        check("rstp_found", 32'(found), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rstp_coin_insert", 32'(bus.coin_insert), 0);
        check("rstp_coin_type",   32'(bus.coin_type), 0);
        check("rstp_return_coin", 32'(bus.return_coin), 0);
        check("rstp_slot_block",  32'(slot_block), 0);
        check("rstp_sense_err",   32'(sense_err), 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        bus.en = 1'b1;
        repeat (20) @(negedge clk);
        check("rstp_no_coin", 32'(bus.coin_insert), 0);
        check("rstp_block", 32'(slot_block), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
